// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: writes received bytes into the buffer,
// then drains a complete frame to the consumer over valid/ready.
module uart_rx_frame_ctrl #(
    parameter int FRAME_LEN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       buf_wr,
    output logic [7:0] buf_w_data,
    output logic [2:0] buf_addr,
    input  logic [7:0] buf_r_data,
    output logic       frame_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] byte_cnt,
    output logic       overrun,
    input  logic       ovr_clr
);

    typedef enum logic [1:0] {
        FILL,
        LOAD,
        PRESENT
    } state_t;

    localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);

    state_t     state;
    logic [2:0] rd_idx;

    assign buf_wr     = rx_done_tick && (state == FILL);
    assign buf_w_data = rx_dout;
    assign buf_addr   = rd_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            byte_cnt    <= 3'd0;
            rd_idx      <= 3'd0;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // a dropped byte outranks a clear in the same cycle
            if (rx_done_tick && (state != FILL))
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            unique case (state)
                FILL: begin
                    if (rx_done_tick) begin
                        if (byte_cnt == LAST) begin
                            byte_cnt    <= 3'd0;
                            rd_idx      <= 3'd0;
                            frame_ready <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                LOAD: begin
                    out_data  <= buf_r_data;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_idx == LAST) begin
                            rd_idx      <= 3'd0;
                            frame_ready <= 1'b0;
                            state       <= FILL;
                        end else begin
                            rd_idx <= rd_idx + 3'd1;
                            state  <= LOAD;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: buffer model plus write/read scoreboards.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       buf_wr;
    logic [7:0] buf_w_data;
    logic [2:0] buf_addr;
    logic [7:0] buf_r_data;
    logic       frame_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] byte_cnt;
    logic       overrun;
    logic       ovr_clr = 1'b0;

    logic       rx_done_tick1 = 1'b0;
    logic [7:0] rx_dout1 = 8'h00;
    logic       buf_wr1;
    logic [7:0] buf_w_data1;
    logic [2:0] buf_addr1;
    logic [7:0] buf_r_data1;
    logic       frame_ready1;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic [2:0] byte_cnt1;
    logic       overrun1;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq[$];
    logic [7:0] rq[$];

    logic [7:0] mem[8];
    logic [2:0] wp;
    logic [7:0] mem1;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.FRAME_LEN(5)) dut (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
        .buf_wr(buf_wr), .buf_w_data(buf_w_data),
        .buf_addr(buf_addr), .buf_r_data(buf_r_data),
        .frame_ready(frame_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .byte_cnt(byte_cnt), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    uart_rx_frame_ctrl #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_done_tick1), .rx_dout(rx_dout1),
        .buf_wr(buf_wr1), .buf_w_data(buf_w_data1),
        .buf_addr(buf_addr1), .buf_r_data(buf_r_data1),
        .frame_ready(frame_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .byte_cnt(byte_cnt1), .overrun(overrun1), .ovr_clr(ovr_clr)
    );

    // receive buffer with its own wrapping write pointer
    always @(posedge clk) begin
        if (reset) begin
            wp <= 3'd0;
        end else if (buf_wr) begin
            mem[wp] <= buf_w_data;
            wp <= (wp == 3'd4) ? 3'd0 : wp + 3'd1;
        end
        if (buf_wr1) mem1 <= buf_w_data1;
    end
    assign buf_r_data  = mem[buf_addr];
    assign buf_r_data1 = mem1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (buf_wr) begin
                if (wq.size() == 0) chk("wr_unexp", 32'd1, 32'd0);
                else chk("wr_data", 32'(buf_w_data), 32'(wq.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (rq.size() == 0) chk("rd_unexp", 32'd1, 32'd0);
                else chk("rd_data", 32'(out_data), 32'(rq.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [7:0] b, input logic acc);
        rx_done_tick = 1'b1;
        rx_dout = b;
        if (acc) begin
            wq.push_back(b);
            rq.push_back(b);
        end
        #1;
        chk("buf_wr", 32'(buf_wr), 32'(acc));
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wq.delete();
        rq.delete();
    endtask

    task automatic drain(input int lim);
        int n = 0;
        out_ready = 1'b1;
        while ((rq.size() != 0 || frame_ready) && n < lim) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < lim), 32'd1);
        chk("wq_empty", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[5];
        fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
        fr[3] = 8'h44; fr[4] = 8'h55;

        step();
        do_reset();
        chk("rst_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_frdy", 32'(frame_ready), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_addr", 32'(buf_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        // spaced ticks, then a free-running drain at a 2-cycle cadence
        for (int i = 0; i < 5; i++) begin
            tick(fr[i], 1'b1);
            chk("byte_cnt", 32'(byte_cnt), 32'((i + 1) % 5));
            if (i < 4) begin
                chk("frdy_fill", 32'(frame_ready), 32'd0);
                step();
                step();
            end
        end
        chk("frdy_load", 32'(frame_ready), 32'd1);
        chk("valid_load", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("valid_pres", 32'(out_valid), 32'd1);
            chk("addr_pres", 32'(buf_addr), 32'(k));
            step();
            chk("valid_drop", 32'(out_valid), 32'd0);
        end
        chk("frdy_end", 32'(frame_ready), 32'd0);
        chk("addr_end", 32'(buf_addr), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        // back-to-back ticks, then backpressure on the third byte
        for (int i = 0; i < 5; i++) tick(fr[i], 1'b1);
        chk("b2b_load", 32'(frame_ready), 32'd1);
        chk("b2b_valid", 32'(out_valid), 32'd0);
        repeat (4) step();
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h33);
            step();
        end
        drain(50);

        // overrun during a stalled PRESENT
        for (int i = 0; i < 5; i++) tick(8'hA1 + 8'(i), 1'b1);
        out_ready = 1'b0;
        step();
        tick(8'hAA, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        ovr_clr = 1'b1;
        tick(8'hBB, 1'b0);
        ovr_clr = 1'b0;
        chk("ovr_win", 32'(overrun), 32'd1);
        chk("ovr_data", 32'(out_data), 32'hA1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        drain(50);

        // tick on the final handshake is dropped, next one is accepted
        for (int i = 0; i < 5; i++) tick(8'hC1 + 8'(i), 1'b1);
        out_ready = 1'b1;
        repeat (9) step();
        chk("last_pres", 32'(out_valid), 32'd1);
        tick(8'hEE, 1'b0);
        chk("last_ovr", 32'(overrun), 32'd1);
        chk("last_fill", 32'(frame_ready), 32'd0);
        tick(8'hD0, 1'b1);
        chk("next_cnt", 32'(byte_cnt), 32'd1);

        // reset mid-frame
        tick(8'hD1, 1'b1);
        tick(8'hD2, 1'b1);
        do_reset();
        chk("mid_cnt", 32'(byte_cnt), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_frdy", 32'(frame_ready), 32'd0);
        chk("mid_ovr", 32'(overrun), 32'd0);

        // reset while presenting the second byte
        for (int i = 0; i < 5; i++) tick(8'hE1 + 8'(i), 1'b1);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        step();
        chk("pre_valid", 32'(out_valid), 32'd1);
        chk("pre_addr", 32'(buf_addr), 32'd1);
        do_reset();
        chk("drst_valid", 32'(out_valid), 32'd0);
        chk("drst_data", 32'(out_data), 32'd0);
        chk("drst_addr", 32'(buf_addr), 32'd0);
        out_ready = 1'b1;

        // single-byte frames
        rx_done_tick1 = 1'b1;
        rx_dout1 = 8'h5A;
        #1;
        chk("f1_wr", 32'(buf_wr1), 32'd1);
        step();
        rx_done_tick1 = 1'b0;
        chk("f1_load", 32'(frame_ready1), 32'd1);
        chk("f1_vload", 32'(out_valid1), 32'd0);
        out_ready1 = 1'b0;
        step();
        chk("f1_valid", 32'(out_valid1), 32'd1);
        chk("f1_data", 32'(out_data1), 32'h5A);
        rx_done_tick1 = 1'b1;
        rx_dout1 = 8'h77;
        #1;
        chk("f1_nowr", 32'(buf_wr1), 32'd0);
        step();
        rx_done_tick1 = 1'b0;
        chk("f1_ovr", 32'(overrun1), 32'd1);
        chk("f1_data2", 32'(out_data1), 32'h5A);
        out_ready1 = 1'b1;
        step();
        chk("f1_fill", 32'(frame_ready1), 32'd0);
        chk("f1_vdrop", 32'(out_valid1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
